stumps_bist_ctrl: RTL and testbench
===================================

# stumps_bist_ctrl

BIST sequencer for the STUMPS self-test structure. It runs a complete self-test session on the scan-chain/LFSR/MISR datapath: it resets the pattern generator and the signature register, then alternates scan-shift and capture phases for a programmed number of patterns. It then flushes the final capture into the MISR and compares the signature against a golden value. It sits above the STUMPS datapath, driving its test-control and reset inputs and reading back its MISR signature.

## Interface
- `CHAIN_LEN`, 3: scan-chain length; shift cycles per pattern (≥1).
- `NUM_PATTERNS`, 16: capture cycles per session (≥1).
- `SIG_W`, 3: MISR signature width.
- `GOLDEN_SIG`, 3'b000: expected signature; `SIG_W` bits.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a session; sampled in IDLE or DONE.
- `abort`  in  1: cancel the running session.
- `sig_in`  in  SIG_W: MISR signature from the datapath.
- `TC`  out  1: test control to the datapath. 0 = scan shift (LFSR and chains shift). 1 = capture/functional.
- `dp_rst`  out  1: synchronous reset to the datapath's LFSR, MISR and scan registers.
- `busy`  out  1: session in progress (INIT through COMPARE).
- `done`  out  1: session finished; held in DONE.
- `pass`  out  1: valid while `done`=1; 1 when `sig_in` matched `GOLDEN_SIG` at COMPARE.
- `pat_cnt`  out  $clog2(NUM_PATTERNS+1): number of captures completed in the current session.

## Operation
- FSM states: IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE.
- **IDLE:** `TC`=1, `dp_rst`=0. If `start`=1, go to INIT.
- **INIT (1 cycle):** `dp_rst`=1, `TC`=1. Clear `shift_cnt`, `pat_cnt` and `pass`. Go to SHIFT.
- **SHIFT (`CHAIN_LEN` cycles):** `TC`=0. `shift_cnt` counts 0..CHAIN_LEN-1. On the last count, clear it and go to CAPTURE.
- **CAPTURE (1 cycle):** `TC`=1. Increment `pat_cnt`.
  - If `pat_cnt`+1 == NUM_PATTERNS, go to FLUSH.
  - Otherwise go to SHIFT.
- **FLUSH (`CHAIN_LEN` cycles):** `TC`=0. Unloads the final capture into the MISR. Then go to COMPARE.
- **COMPARE (1 cycle):** `TC`=1. Register `pass` <= (`sig_in` == `GOLDEN_SIG`). Go to DONE.
- **DONE:** `done`=1, `busy`=0, `TC`=1. `pass` and `pat_cnt` hold. If `start`=1, go to INIT (restart); otherwise stay.
- **`abort`:** when `abort`=1 in any state from INIT to COMPARE, the next state is IDLE. `done` is not asserted and `pass` is cleared. `abort` has priority over all other transitions. It is ignored in IDLE and DONE.
- `start` is ignored while `busy`=1.
- `rst` has priority over everything. If asserted mid-session, the FSM goes to IDLE on the next edge.
- `pat_cnt` never exceeds NUM_PATTERNS. Counters never wrap within a session.

## Timing
- All outputs are registered. Their values are state-decoded from registered state.
- Reset values: `TC`=1, `dp_rst`=0, `busy`=0, `done`=0, `pass`=0, `pat_cnt`=0. The FSM resets to IDLE.
- `start` sampled high at edge N → INIT is active in cycle N+1.
- Session length from INIT to the first DONE cycle: 1 + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles. With the defaults this is 69 cycles.
- `TC` low-run lengths:
  - exactly CHAIN_LEN cycles per SHIFT phase;
  - each run is separated by a single-cycle high (CAPTURE);
  - the final run is FLUSH, CHAIN_LEN cycles.
- `sig_in` is sampled only in COMPARE. It reflects the MISR after the last FLUSH shift edge.
- `dp_rst` is a single-cycle pulse, high only in INIT.

## Test plan
- **Golden run:** defaults, `GOLDEN_SIG` set to the datapath's known-good signature, `start` pulse → `busy` high for 69 cycles, then `done`=1, `pass`=1, `pat_cnt`=16.
- **Bad signature:** the same run with `GOLDEN_SIG` inverted (or one `sig_in` bit forced) → `done`=1, `pass`=0, `pat_cnt`=16.
- **`TC` waveform check:**
  - `CHAIN_LEN`=3, `NUM_PATTERNS`=2, `start`.
  - Required `TC` sequence from INIT: 1,0,0,0,1,0,0,0,1,0,0,0,1, then held 1.
  - `dp_rst` is high only in the first cycle.
- **Abort:** assert `abort` during the 5th SHIFT phase → IDLE on the next cycle, `done`=0, `pass`=0, `TC`=1. A later `start` gives a full 69-cycle session.
- **Reset mid-session:** assert `rst` while in CAPTURE → all outputs at reset values on the next cycle. `start` held high during the session, or pulsed in DONE, restarts only from IDLE/DONE.
- **Back-to-back:** `start` held high continuously → the session repeats. Each DONE lasts 1 cycle, then INIT. `pat_cnt` resets to 0 at each INIT.

Source files
------------

// File: rtl/stumps_bist_ctrl.sv
// -----------------------------------------------------------------------------
// stumps_bist_ctrl
//
// BIST session sequencer for a STUMPS self-test datapath. A session resets
// the LFSR/MISR/scan registers, then alternates scan-shift and capture phases
// for NUM_PATTERNS patterns. It flushes the last capture into the MISR and
// compares the resulting signature against GOLDEN_SIG.
//
// Parameters:
//   CHAIN_LEN    - scan-chain length, i.e. shift cycles per pattern (>= 1)
//   NUM_PATTERNS - capture cycles per session (>= 1)
//   SIG_W        - MISR signature width
//   GOLDEN_SIG   - known-good signature
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   begin a session (honoured in IDLE and DONE only)
//   abort    in   cancel a running session (INIT..COMPARE)
//   sig_in   in   MISR signature from the datapath, sampled in COMPARE
//   TC       out  test control: 0 = scan shift, 1 = capture/functional
//   dp_rst   out  one-cycle datapath reset pulse, high in INIT only
//   busy     out  session in progress (INIT..COMPARE)
//   done     out  session finished, held while in DONE
//   pass     out  signature matched GOLDEN_SIG (meaningful while done = 1)
//   pat_cnt  out  captures completed in the current session
// -----------------------------------------------------------------------------
module stumps_bist_ctrl #(
    parameter int                CHAIN_LEN    = 3,
    parameter int                NUM_PATTERNS = 16,
    parameter int                SIG_W        = 3,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG   = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [SIG_W-1:0]                    sig_in,
    output logic                                TC,
    output logic                                dp_rst,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pat_cnt
);

    localparam int PC_W = $clog2(NUM_PATTERNS + 1);
    // A single-cycle chain still needs a 1-bit counter.
    localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PAT_LAST   = PC_W'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [PC_W-1:0]   pat_cnt_q,   pat_cnt_d;
    logic              pass_q,      pass_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            pass_q      <= pass_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a hold-value default before the case so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        pass_d      = pass_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                shift_cnt_d = '0;
                pat_cnt_d   = '0;
                pass_d      = 1'b0;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    shift_cnt_d = '0;
                    state_d     = S_CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            S_CAPTURE: begin
                // Compare against the pre-increment value: the capture in
                // flight is the last one when the count is NUM_PATTERNS-1.
                pat_cnt_d = pat_cnt_q + PC_W'(1);
                state_d   = (pat_cnt_q == PAT_LAST) ? S_FLUSH : S_SHIFT;
            end
            S_FLUSH: begin
                // FLUSH reuses the shift counter to unload the final capture.
                if (shift_cnt_q == SHIFT_LAST) begin
                    shift_cnt_d = '0;
                    state_d     = S_COMPARE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            S_COMPARE: begin
                pass_d  = (sig_in == GOLDEN_SIG);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_INIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every in-session transition; IDLE and DONE ignore it.
        if (abort && (state_q inside {S_INIT, S_SHIFT, S_CAPTURE, S_FLUSH, S_COMPARE})) begin
            state_d     = S_IDLE;
            shift_cnt_d = '0;
            pass_d      = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: pure decode of registered state, so glitch-free and
    // available right after the edge.
    // -------------------------------------------------------------------------
    assign TC      = !(state_q inside {S_SHIFT, S_FLUSH});
    assign dp_rst  = (state_q == S_INIT);
    assign busy    = (state_q inside {S_INIT, S_SHIFT, S_CAPTURE, S_FLUSH, S_COMPARE});
    assign done    = (state_q == S_DONE);
    assign pass    = pass_q;
    assign pat_cnt = pat_cnt_q;

endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stumps_bist_ctrl
//
// Two instances of stumps_bist_ctrl: a default-sized one (3 x 16 patterns) and
// a small one (3 x 2 patterns) for exact TC waveform checks. Each cycle the
// expected outputs are computed from the position within the session,
// queued, and then compared after the next rising edge.
// -----------------------------------------------------------------------------
module tb_stumps_bist_ctrl;

    localparam int         B_CL   = 3;
    localparam int         B_NP   = 16;
    localparam int         S_CL   = 3;
    localparam int         S_NP   = 2;
    localparam logic [2:0] B_GOLD = 3'b101;
    localparam logic [2:0] S_GOLD = 3'b010;

    logic       clk = 1'b0;
    logic       rst;

    logic       b_start, b_abort;
    logic [2:0] b_sig;
    logic       b_tc, b_dp_rst, b_busy, b_done, b_pass;
    logic [4:0] b_pat_cnt;

    logic       s_start, s_abort;
    logic [2:0] s_sig;
    logic       s_tc, s_dp_rst, s_busy, s_done, s_pass;
    logic [1:0] s_pat_cnt;

    always #5 clk = ~clk;

    stumps_bist_ctrl #(
        .CHAIN_LEN(B_CL), .NUM_PATTERNS(B_NP), .SIG_W(3), .GOLDEN_SIG(B_GOLD)
    ) u_big (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .sig_in(b_sig),
        .TC(b_tc), .dp_rst(b_dp_rst), .busy(b_busy), .done(b_done),
        .pass(b_pass), .pat_cnt(b_pat_cnt)
    );

    stumps_bist_ctrl #(
        .CHAIN_LEN(S_CL), .NUM_PATTERNS(S_NP), .SIG_W(3), .GOLDEN_SIG(S_GOLD)
    ) u_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .sig_in(s_sig),
        .TC(s_tc), .dp_rst(s_dp_rst), .busy(s_busy), .done(s_done),
        .pass(s_pass), .pat_cnt(s_pat_cnt)
    );

    typedef struct {
        string tag;
        logic  tc;
        logic  dp_rst;
        logic  busy;
        logic  done;
        logic  pass;
        int    pat_cnt;
        bit    chk_pass;
        bit    chk_cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sel_small = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expected outputs at cycle offset pos from INIT (pos 0 = INIT).
    function automatic exp_t model(input int pos, input int cl, input int np,
                                   input bit good, input string tag);
        exp_t e;
        int   len;
        len        = 1 + np * (cl + 1) + cl + 1;
        e.tag      = $sformatf("%s@%0d", tag, pos);
        e.dp_rst   = 1'b0;
        e.busy     = 1'b1;
        e.done     = 1'b0;
        e.pass     = 1'b0;
        e.chk_pass = 1'b1;
        e.chk_cnt  = 1'b1;
        if (pos == 0) begin
            e.tc = 1'b1; e.dp_rst = 1'b1; e.pat_cnt = 0;
            e.chk_pass = 1'b0; e.chk_cnt = 1'b0;
        end else if (pos <= np * (cl + 1)) begin
            e.tc      = (((pos - 1) % (cl + 1)) == cl);
            e.pat_cnt = (pos - 1) / (cl + 1);
        end else if (pos <= np * (cl + 1) + cl) begin
            e.tc = 1'b0; e.pat_cnt = np;
        end else if (pos == len - 1) begin
            e.tc = 1'b1; e.pat_cnt = np;
        end else begin
            e.tc = 1'b1; e.busy = 1'b0; e.done = 1'b1; e.pass = good; e.pat_cnt = np;
        end
        return e;
    endfunction

    function automatic exp_t idle_exp(input string tag, input bit chk_cnt);
        exp_t e;
        e.tag = tag; e.tc = 1'b1; e.dp_rst = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        e.pass = 1'b0; e.pat_cnt = 0; e.chk_pass = 1'b1; e.chk_cnt = chk_cnt;
        return e;
    endfunction

    task automatic set_in(input logic st, input logic ab, input logic [2:0] sg);
        if (sel_small) begin
            s_start = st; s_abort = ab; s_sig = sg;
        end else begin
            b_start = st; b_abort = ab; b_sig = sg;
        end
    endtask

    // Advance one clock, then pop the oldest expectation and compare.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        if (sel_small) begin
            check({e.tag, ".tc"},     {31'd0, s_tc},     {31'd0, e.tc});
            check({e.tag, ".dp_rst"}, {31'd0, s_dp_rst}, {31'd0, e.dp_rst});
            check({e.tag, ".busy"},   {31'd0, s_busy},   {31'd0, e.busy});
            check({e.tag, ".done"},   {31'd0, s_done},   {31'd0, e.done});
            if (e.chk_pass) check({e.tag, ".pass"},    {31'd0, s_pass},    {31'd0, e.pass});
            if (e.chk_cnt)  check({e.tag, ".pat_cnt"}, {30'd0, s_pat_cnt}, e.pat_cnt);
        end else begin
            check({e.tag, ".tc"},     {31'd0, b_tc},     {31'd0, e.tc});
            check({e.tag, ".dp_rst"}, {31'd0, b_dp_rst}, {31'd0, e.dp_rst});
            check({e.tag, ".busy"},   {31'd0, b_busy},   {31'd0, e.busy});
            check({e.tag, ".done"},   {31'd0, b_done},   {31'd0, e.done});
            if (e.chk_pass) check({e.tag, ".pass"},    {31'd0, b_pass},    {31'd0, e.pass});
            if (e.chk_cnt)  check({e.tag, ".pat_cnt"}, {27'd0, b_pat_cnt}, e.pat_cnt);
        end
    endtask

    // Full session from IDLE/DONE through the first DONE cycle. sig_in carries
    // the chosen signature only during COMPARE, and ~golden everywhere else.
    task automatic run_session(input string tag, input bit bad, input bit hold);
        int         cl, np, len;
        logic [2:0] gold, sig_cmp;
        cl      = sel_small ? S_CL : B_CL;
        np      = sel_small ? S_NP : B_NP;
        gold    = sel_small ? S_GOLD : B_GOLD;
        sig_cmp = bad ? (gold ^ 3'b001) : gold;
        len     = 1 + np * (cl + 1) + cl + 1;
        set_in(1'b1, 1'b0, ~gold);
        sb_q.push_back(model(0, cl, np, !bad, tag));
        step();
        for (int q = 1; q <= len; q++) begin
            set_in(hold, 1'b0, (q == len) ? sig_cmp : ~gold);
            sb_q.push_back(model(q, cl, np, !bad, tag));
            step();
        end
        set_in(1'b0, 1'b0, ~gold);
    endtask

    task automatic hold_done(input string tag, input bit good, input int n);
        int cl, np, len;
        cl  = sel_small ? S_CL : B_CL;
        np  = sel_small ? S_NP : B_NP;
        len = 1 + np * (cl + 1) + cl + 1;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(model(len, cl, np, good, tag));
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        b_start = 1'b0; b_abort = 1'b0; b_sig = ~B_GOLD;
        s_start = 1'b0; s_abort = 1'b0; s_sig = ~S_GOLD;

        // Reset values on both instances.
        sel_small = 1'b0;
        sb_q.push_back(idle_exp("reset_big", 1'b1));
        step();
        sel_small = 1'b1;
        sb_q.push_back(idle_exp("reset_small", 1'b1));
        step();
        #1 rst = 1'b0;

        // Golden run and bad-signature run on the default-size instance.
        sel_small = 1'b0;
        run_session("golden", 1'b0, 1'b0);
        hold_done("golden_hold", 1'b1, 2);
        run_session("bad_sig", 1'b1, 1'b0);
        hold_done("bad_hold", 1'b0, 2);

        // Abort during the 5th SHIFT phase (positions 17..19).
        set_in(1'b1, 1'b0, ~B_GOLD);
        sb_q.push_back(model(0, B_CL, B_NP, 1'b1, "abort_run"));
        step();
        for (int q = 1; q <= 18; q++) begin
            set_in(1'b0, 1'b0, ~B_GOLD);
            sb_q.push_back(model(q, B_CL, B_NP, 1'b1, "abort_run"));
            step();
        end
        set_in(1'b0, 1'b1, ~B_GOLD);
        sb_q.push_back(idle_exp("abort_idle", 1'b0));
        step();
        // Abort is ignored in IDLE.
        sb_q.push_back(idle_exp("abort_in_idle", 1'b0));
        step();
        set_in(1'b0, 1'b0, ~B_GOLD);
        sb_q.push_back(idle_exp("after_abort", 1'b0));
        step();
        run_session("post_abort", 1'b0, 1'b0);
        hold_done("post_abort_hold", 1'b1, 1);

        // Exact TC waveform on the small instance.
        sel_small = 1'b1;
        run_session("tc_wave", 1'b0, 1'b0);
        hold_done("tc_wave_hold", 1'b1, 2);

        // Reset while in CAPTURE (position 4).
        set_in(1'b1, 1'b0, ~S_GOLD);
        sb_q.push_back(model(0, S_CL, S_NP, 1'b1, "rst_mid"));
        step();
        for (int q = 1; q <= 4; q++) begin
            set_in(1'b1, 1'b0, ~S_GOLD);
            sb_q.push_back(model(q, S_CL, S_NP, 1'b1, "rst_mid"));
            step();
        end
        rst = 1'b1;
        set_in(1'b0, 1'b0, ~S_GOLD);
        sb_q.push_back(idle_exp("rst_mid_reset", 1'b1));
        step();
        rst = 1'b0;
        sb_q.push_back(idle_exp("rst_mid_idle", 1'b1));
        step();

        // Back-to-back sessions with start held high throughout.
        run_session("b2b_1", 1'b0, 1'b1);
        run_session("b2b_2", 1'b0, 1'b1);
        run_session("b2b_3", 1'b0, 1'b0);
        hold_done("b2b_hold", 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
